// File: rtl/text_vga_pkg.sv
// Shared types and constants for the 80x30 VGA text-mode display.
//   VRAM_WORDS / CTRL_ADDR : VRAM depth; the control register sits at the first word past it
//   CTRL_RESET             : white foreground on black background
//   ctrl_reg_t             : field layout of the colour control register
//   addr_cls_e/addr_class  : host address decode into RAM / control register / out of range
package text_vga_pkg;

   localparam int unsigned VRAM_WORDS = 600;
   localparam int unsigned CTRL_ADDR  = 600;
   localparam logic [31:0] CTRL_RESET = 32'h01FF_E000;

   typedef struct packed {
      logic [6:0] rsvd_hi;   // stored as written, no display meaning
      logic [3:0] fgd_r;
      logic [3:0] fgd_g;
      logic [3:0] fgd_b;
      logic [3:0] bkg_r;
      logic [3:0] bkg_g;
      logic [3:0] bkg_b;
      logic       rsvd_lo;   // stored as written, no display meaning
   } ctrl_reg_t;

   typedef enum logic [1:0] {
      ClsRam,
      ClsCtrl,
      ClsOor
   } addr_cls_e;

   // Words below the VRAM depth hit the RAM, the depth itself is the control
   // register, everything above is accepted but has no backing storage.
   function automatic addr_cls_e addr_class(input int unsigned addr, input int unsigned words);
      if (addr < words) begin
         return ClsRam;
      end else if (addr == words) begin
         return ClsCtrl;
      end
      return ClsOor;
   endfunction

endpackage

// File: rtl/text_vga_ctrl_reg.sv
// Byte-enabled colour control register.
//   CLK, RESET_N : clock, asynchronous active-low reset (loads CTRL_RESET)
//   wr_en        : write strobe, one cycle per accepted host write
//   byte_en      : per-byte write enables
//   wr_data      : write data
//   ctrl         : register contents, updated the cycle after the write
module text_vga_ctrl_reg
   import text_vga_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        wr_en,
   input  logic [3:0]  byte_en,
   input  logic [31:0] wr_data,
   output logic [31:0] ctrl
);

   ctrl_reg_t ctrl_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ctrl_q <= ctrl_reg_t'(CTRL_RESET);
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               ctrl_q[8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   assign ctrl = ctrl_q;

endmodule

// File: rtl/text_vram_arbiter.sv
// Single-port VRAM arbiter and colour control-register owner for the text display.
// One RAM access per cycle, shared between the Avalon-MM host and the glyph fetcher.
//   CLK, RESET_N                     : clock, asynchronous active-low reset
//   AVL_CS/READ/WRITE/BYTE_EN/ADDR/WRITEDATA : Avalon-MM slave command side
//   AVL_WAITREQUEST                  : host stall (combinational)
//   AVL_READDATA/AVL_READDATAVALID   : host read response, fixed latency 2
//   DISP_REQ/DISP_ADDR               : fetcher read request
//   DISP_GNT                         : fetcher request accepted this cycle
//   DISP_VALID/DISP_RDATA            : fetched word, one cycle after the grant
//   RAM_ADDR/WE/BE/WDATA, RAM_RDATA  : synchronous RAM port, 1-cycle read latency
//   CTRL_REG                         : colour control register (word VRAM_WORDS)
// Build option: define VRAM_ARB_STARVE_GUARD_EN to force a host grant after MAX_WAIT
// consecutive denied cycles; otherwise the display has strict priority.
module text_vram_arbiter #(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned VRAM_WORDS = 600,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              AVL_CS,
   input  logic              AVL_READ,
   input  logic              AVL_WRITE,
   input  logic [3:0]        AVL_BYTE_EN,
   input  logic [ADDR_W-1:0] AVL_ADDR,
   input  logic [DATA_W-1:0] AVL_WRITEDATA,
   output logic              AVL_WAITREQUEST,
   output logic [DATA_W-1:0] AVL_READDATA,
   output logic              AVL_READDATAVALID,
   input  logic              DISP_REQ,
   input  logic [ADDR_W-1:0] DISP_ADDR,
   output logic              DISP_GNT,
   output logic              DISP_VALID,
   output logic [DATA_W-1:0] DISP_RDATA,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic              RAM_WE,
   output logic [3:0]        RAM_BE,
   output logic [DATA_W-1:0] RAM_WDATA,
   input  logic [DATA_W-1:0] RAM_RDATA,
   output logic [DATA_W-1:0] CTRL_REG
);

   import text_vga_pkg::*;

   addr_cls_e         host_cls;
   logic              host_req;
   logic              host_wr;
   logic              host_rd;
   logic              host_ram;
   logic              ram_conflict;
   logic              host_forced;
   logic              host_accept;
   logic              ctrl_wr;
   logic [DATA_W-1:0] ctrl;
   logic [DATA_W-1:0] rd_data;

   // Read-tag pipeline: stage 1 remembers which source to sample, stage 2 is the response.
   logic              rd_vld_q;
   addr_cls_e         rd_cls_q;
   logic              rdv_q;
   logic [DATA_W-1:0] rdata_q;
   logic              disp_vld_q;

   assign host_cls = addr_class(32'(AVL_ADDR), VRAM_WORDS);

   always_comb begin
      host_req     = AVL_CS & (AVL_READ | AVL_WRITE);
      // READ and WRITE together count as a write.
      host_wr      = host_req & AVL_WRITE;
      host_rd      = host_req & AVL_READ & ~AVL_WRITE;
      host_ram     = host_req & (host_cls == ClsRam);
      ram_conflict = host_ram & DISP_REQ;
   end

`ifdef VRAM_ARB_STARVE_GUARD_EN
   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] starve_q;
   logic [CNT_W-1:0] starve_d;

   assign host_forced = ram_conflict & (starve_q == CNT_W'(MAX_WAIT));

   // Counts consecutive denied host RAM cycles; any accept or dropped request clears it.
   always_comb begin
      starve_d = '0;
      if (host_ram && !host_accept) begin
         starve_d = (starve_q == CNT_W'(MAX_WAIT)) ? starve_q : starve_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign host_forced = 1'b0;
`endif

   // Reset gates the handshake directly so nothing is granted while RESET_N is low.
   always_comb begin
      AVL_WAITREQUEST = ~RESET_N | (ram_conflict & ~host_forced);
      DISP_GNT        = RESET_N & DISP_REQ & ~host_forced;
      host_accept     = host_req & ~AVL_WAITREQUEST;
      ctrl_wr         = host_accept & host_wr & (host_cls == ClsCtrl);
   end

   always_comb begin
      RAM_ADDR  = AVL_ADDR;
      RAM_WE    = 1'b0;
      RAM_BE    = 4'b0000;
      RAM_WDATA = AVL_WRITEDATA;
      if (DISP_GNT) begin
         RAM_ADDR = DISP_ADDR;
      end else if (host_accept && host_ram && host_wr) begin
         RAM_WE = 1'b1;
         RAM_BE = AVL_BYTE_EN;
      end
   end

   text_vga_ctrl_reg u_ctrl_reg (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .wr_en   (ctrl_wr),
      .byte_en (AVL_BYTE_EN),
      .wr_data (AVL_WRITEDATA),
      .ctrl    (ctrl)
   );

   // Sampled one cycle after accept, when the RAM word is on RAM_RDATA. A control-register
   // write cannot land in that cycle's predecessor, so ctrl already holds the right value.
   always_comb begin
      rd_data = '0;
      unique case (rd_cls_q)
         ClsRam:  rd_data = RAM_RDATA;
         ClsCtrl: rd_data = ctrl;
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rd_vld_q   <= 1'b0;
         rd_cls_q   <= ClsRam;
         rdv_q      <= 1'b0;
         rdata_q    <= '0;
         disp_vld_q <= 1'b0;
      end else begin
         rd_vld_q   <= host_accept & host_rd;
         rd_cls_q   <= host_cls;
         rdv_q      <= rd_vld_q;
         disp_vld_q <= DISP_GNT;
         if (rd_vld_q) begin
            rdata_q <= rd_data;
         end
      end
   end

   assign AVL_READDATA      = rdata_q;
   assign AVL_READDATAVALID = rdv_q;
   assign DISP_VALID        = disp_vld_q;
   assign DISP_RDATA        = RAM_RDATA;
   assign CTRL_REG          = ctrl;

endmodule

// File: doc/text_vram_arbiter.md
# text_vram_arbiter

Single-port VRAM arbiter and control-register owner for the 80x30 VGA text-mode display. It shares one synchronous 600x32 VRAM between the Avalon-MM host and the display glyph fetcher, one RAM access per cycle. It also holds the colour control register at word 600. It sits between the Avalon slave boundary and the pixel pipeline.

## Interface
Parameters:
- ADDR_W, 10, word address width
- DATA_W, 32, word width
- VRAM_WORDS, 600, RAM depth; also the control-register address
- MAX_WAIT, 4, host-denied cycles before forced host grant (guard build only)

Ports:
- CLK  in  1  system clock, 50 MHz
- RESET_N  in  1  asynchronous, active-low reset
- AVL_CS / AVL_READ / AVL_WRITE  in  1  Avalon-MM select and commands
- AVL_BYTE_EN  in  4  byte enables
- AVL_ADDR  in  ADDR_W  word address
- AVL_WRITEDATA  in  DATA_W  write data
- AVL_WAITREQUEST  out  1  host stall
- AVL_READDATA  out  DATA_W  read data
- AVL_READDATAVALID  out  1  read-data strobe
- DISP_REQ  in  1  fetcher read request
- DISP_ADDR  in  ADDR_W  fetcher word address
- DISP_GNT  out  1  fetcher request accepted this cycle
- DISP_VALID  out  1  DISP_RDATA valid
- DISP_RDATA  out  DATA_W  fetched VRAM word
- RAM_ADDR  out  ADDR_W  RAM address
- RAM_WE  out  1  RAM write enable
- RAM_BE  out  4  RAM byte enables
- RAM_WDATA  out  DATA_W  RAM write data
- RAM_RDATA  in  DATA_W  RAM read data, 1-cycle latency
- CTRL_REG  out  DATA_W  control register: [24:21] FGD_R, [20:17] FGD_G, [16:13] FGD_B, [12:9] BKG_R, [8:5] BKG_G, [4:1] BKG_B

## Operation
- Host request: AVL_CS & (AVL_READ | AVL_WRITE).
- Transfer accepted in any cycle where the host request is present and AVL_WAITREQUEST=0.
- READ and WRITE both high: treated as a write; no AVL_READDATAVALID is produced.
- Address classes:
  - 0..599: RAM access.
  - 600: control register; never touches the RAM and never waits.
  - 601..1023: accepted with no wait; writes dropped; reads return 0.
- Arbitration applies only when the host targets the RAM and DISP_REQ=1 in the same cycle.
  - Default: display wins; DISP_GNT=1; AVL_WAITREQUEST=1.
- Host control-register and out-of-range accesses are accepted in the same cycle as a display grant.
- RAM write: RAM_WE=1, RAM_BE=AVL_BYTE_EN, RAM_WDATA=AVL_WRITEDATA; any byte-enable pattern is allowed, including 0000 (no-op).
- Control-register write: per-byte update under AVL_BYTE_EN. Bit 0 and bits [31:25] are stored as written.
- Starvation counter (guard build only):
  - Counts cycles with host RAM request present and waitrequest high.
  - Saturates at MAX_WAIT.
  - Clears on host accept or when the host request drops.

## Timing
- RAM command outputs (RAM_ADDR/RAM_WE/RAM_BE/RAM_WDATA) and DISP_GNT/AVL_WAITREQUEST are combinational in accept cycle N.
- Display read: DISP_VALID=1 in N+1; DISP_RDATA = RAM_RDATA, passed through.
- Host read latency is fixed at 2 for every address class:
  - Accept in N; AVL_READDATAVALID=1 with registered AVL_READDATA in N+2.
  - Reads pipeline back-to-back, one per cycle.
- Write visibility:
  - CTRL_REG reflects a write in N+1.
  - A RAM write in N is visible to any read accepted in N+1 or later.
- While RESET_N=0: RAM_WE=0, DISP_GNT=0, AVL_WAITREQUEST=1.
- Reset values: AVL_READDATA=0, AVL_READDATAVALID=0, DISP_VALID=0, CTRL_REG=0x01FFE000 (white on black), counter=0.
- Reset mid-operation drops in-flight read responses; nothing is replayed.

## Configuration
- VRAM_ARB_STARVE_GUARD_EN defined:
  - When the counter equals MAX_WAIT and both requesters target the RAM, the host wins.
  - DISP_GNT=0; the fetcher holds DISP_REQ/DISP_ADDR stable.
  - Counter clears on that host accept.
- Undefined: strict display priority; no counter logic is synthesised.

## Structure
- Package text_vga_pkg:
  - VRAM_WORDS=600, CTRL_ADDR=600, CTRL_RESET=32'h01FFE000.
  - Packed struct ctrl_reg_t for the control-register fields.
  - Enum for address class (RAM / CTRL / OOR).
- Sub-module text_vga_ctrl_reg: byte-enabled control register with async reset to CTRL_RESET.
- Arbitration, read-tag pipeline and starvation counter stay in the top module.

## Test plan
- Host write 0x41424344 to word 5 (BE 1111), then read word 5: AVL_READDATAVALID 2 cycles after accept; data 0x41424344.
- Host RAM read and DISP_REQ in the same cycle (strict build):
  - Display granted; DISP_VALID next cycle.
  - Host waits one cycle, then accepted.
- DISP_REQ held high continuously with a host RAM write pending:
  - Guard build: host accepted after exactly MAX_WAIT=4 wait cycles.
  - Strict build: host never accepted while DISP_REQ stays high.
- Write word 600 with BE 0010 and data 0x0000AB00: CTRL_REG = 0x01FFAB00 next cycle; a DISP_REQ in the same cycle is granted.
- Read word 700: accepted with no wait; AVL_READDATA=0 in N+2. Write word 700: RAM_WE stays 0.
- Assert RESET_N=0 one cycle after a host read accept: no AVL_READDATAVALID ever; CTRL_REG=0x01FFE000.
